// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: BIST stimulus sequencer for a 4-input logic block.
//
// The block walks 16 patterns. Each pattern takes two cycles: APPLY lets the
// logic settle, and SAMPLE reads the comparator's Error_flag. It counts the
// failing patterns and records the first one that fails.
//
// Optional build macro BIST_LFSR_EN: when it is defined, the patterns come
// from a 4-bit Fibonacci LFSR (x^4+x^3+1, seed 4'b0001), and index 15 is
// forced to 4'b0000. When it is not defined, pattern n is simply n. Run
// length and timing are the same in both builds.
module bist_pattern_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Error_flag,
    output logic [3:0] To_Logic_X,
    output logic       Compare_en,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [4:0] Fail_count,
    output logic [3:0] First_fail
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'd15;
    localparam logic [4:0] FAIL_MAX  = 5'd16;

`ifdef BIST_LFSR_EN
    localparam logic [3:0] FIRST_PAT = 4'b0001;
`else
    localparam logic [3:0] FIRST_PAT = 4'b0000;
`endif

    state_t     r_state;
    logic [3:0] r_idx;
    logic [3:0] r_pat;
    logic [4:0] r_fail;
    logic [3:0] r_first;

    logic [3:0] w_next_pat;
    logic       w_fail_sat;

    // Pattern for index r_idx+1. In LFSR mode, r_pat itself holds the LFSR
    // state, because the LFSR is never stepped past index 14.
    always_comb begin
        w_next_pat = 4'd0;
`ifdef BIST_LFSR_EN
        if (r_idx == 4'd14)
            w_next_pat = 4'd0;
        else
            w_next_pat = {r_pat[2:0], r_pat[3] ^ r_pat[2]};
`else
        w_next_pat = r_idx + 4'd1;
`endif
    end

    assign w_fail_sat = (r_fail == FAIL_MAX);

    // Sequencer FSM. Reset comes first. Abort beats Start while a run is
    // active, and Start is only looked at in IDLE or DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_pat   <= 4'd0;
            r_fail  <= 5'd0;
            r_first <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state <= S_APPLY;
                        r_idx   <= 4'd0;
                        r_pat   <= FIRST_PAT;
                        r_fail  <= 5'd0;
                        r_first <= 4'd0;
                    end
                end
                S_APPLY: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= 4'd0;
                        r_pat   <= 4'd0;
                    end else begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= 4'd0;
                        r_pat   <= 4'd0;
                    end else begin
                        if (Error_flag) begin
                            if (!w_fail_sat)
                                r_fail <= r_fail + 5'd1;
                            if (r_fail == 5'd0)
                                r_first <= r_pat;
                        end
                        if (r_idx == LAST_IDX) begin
                            // The last pattern stays on the bus while in DONE.
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_APPLY;
                            r_idx   <= r_idx + 4'd1;
                            r_pat   <= w_next_pat;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= 4'd0;
                    r_pat   <= 4'd0;
                end
            endcase
        end
    end

    assign To_Logic_X = r_pat;
    assign Compare_en = (r_state == S_SAMPLE);
    assign Busy       = (r_state == S_APPLY) || (r_state == S_SAMPLE);
    assign Done       = (r_state == S_DONE);
    assign Pass       = Done && (r_fail == 5'd0);
    assign Fail_count = r_fail;
    assign First_fail = r_first;

endmodule

// File: doc/bist_pattern_gen.md
BIST_PATTERN_GEN -- requirements
Module: bist_pattern_gen

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Start  input  1  run request; sampled only in IDLE and DONE.
REQ-004 SHALL have port: Abort  input  1  cancels a run in progress.
REQ-005 SHALL have port: Error_flag  input  1  mismatch from the BIST comparator (1 = logic output differs from expected).
REQ-006 SHALL have port: To_Logic_X  output  4  stimulus to the logic under test and to the expected-data buffer.
REQ-007 SHALL have port: Compare_en  output  1  high while Error_flag is being sampled.
REQ-008 SHALL have port: Busy  output  1  high in APPLY and SAMPLE.
REQ-009 SHALL have port: Done  output  1  level; high in DONE.
REQ-010 SHALL have port: Pass  output  1  Done and Fail_count == 0.
REQ-011 SHALL have port: Fail_count  output  5  number of failing patterns, range 0..16.
REQ-012 SHALL have port: First_fail  output  4  pattern value of the first failure; 0 if none.

Function
REQ-013 SHALL implement states IDLE, APPLY, SAMPLE and DONE; all outputs SHALL be registered or decoded from registered state.
REQ-014 In IDLE or DONE, Start=1 SHALL, on the next edge, clear Fail_count and First_fail, load pattern index 0, and enter APPLY.
REQ-015 APPLY SHALL last exactly one cycle and present the current pattern on To_Logic_X, with Compare_en=0 so the logic under test can settle.
REQ-016 SHALL move from APPLY to SAMPLE; SAMPLE SHALL last exactly one cycle with Compare_en=1 and To_Logic_X unchanged.
REQ-017 At the end of SAMPLE, if Error_flag=1, Fail_count SHALL increment by 1.
REQ-018 At the end of SAMPLE, if Error_flag=1 and Fail_count was 0, First_fail SHALL capture To_Logic_X.
REQ-019 Error_flag SHALL be ignored in every state other than SAMPLE.
REQ-020 After SAMPLE of pattern index 0..14, the index SHALL increment and the state SHALL return to APPLY.
REQ-021 After SAMPLE of pattern index 15, the state SHALL go to DONE; no wrap to index 0 within a run.
REQ-022 A full run SHALL be 16 patterns x 2 cycles; Done SHALL rise 32 edges after the edge that samples Start.
REQ-023 Fail_count SHALL be 5 bits and SHALL saturate at 16; it cannot exceed 16 by construction.
REQ-024 Start asserted while Busy=1 SHALL be ignored.
REQ-025 Start asserted in DONE SHALL begin a new run, per REQ-014.
REQ-026 Abort=1 in APPLY or SAMPLE SHALL force IDLE on the next edge and set To_Logic_X=0.
REQ-027 On Abort, Fail_count and First_fail SHALL be held, and Done SHALL remain 0.
REQ-028 If Abort and Start are both 1, Abort SHALL win in APPLY/SAMPLE and Start SHALL win in IDLE/DONE.
REQ-029 In IDLE, To_Logic_X SHALL be 0; in DONE, To_Logic_X SHALL hold the last pattern.
REQ-030 Abort in IDLE or DONE SHALL have no effect.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE and clear all outputs: To_Logic_X=0, Compare_en=0, Busy=0, Done=0, Pass=0, Fail_count=0, First_fail=0, pattern index=0.
REQ-032 rst SHALL take priority over Start and Abort, including mid-run; a run SHALL NOT resume after rst deasserts.

Configuration
REQ-033 Macro BIST_LFSR_EN defined: pattern n SHALL come from a 4-bit Fibonacci LFSR, polynomial x^4+x^3+1, seeded with 4'b0001 at Start, giving 15 nonzero states; index 15 SHALL be 4'b0000.
REQ-034 Macro BIST_LFSR_EN undefined: pattern n SHALL equal n (binary count 0..15).
REQ-035 Run length, timing and all other behaviour SHALL be identical with and without BIST_LFSR_EN.

Verification
REQ-036 Reset, then Start pulse with Error_flag=0 throughout -> To_Logic_X sequence 0,0,1,1,...,15,15 (counter mode); Done=1 and Pass=1 at edge 32; Fail_count=0.
REQ-037 Error_flag=1 only while To_Logic_X=5 and 9, Compare_en=1 -> Fail_count=2, First_fail=5, Pass=0.
REQ-038 Error_flag held at 1 for the whole run -> Fail_count=16, First_fail=0 (first pattern), Pass=0.
REQ-039 Abort at edge 10, with Start re-pulsed at edge 12 and again mid-run -> IDLE at edge 11; new run from pattern 0; the mid-run Start is ignored; Done at 32 edges after edge 12.
REQ-040 rst asserted at edge 20 of a run with 1 failure logged -> all outputs 0 at edge 21; stays IDLE until Start.
REQ-041 With BIST_LFSR_EN defined, Error_flag=0 -> To_Logic_X sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,0 (each held 2 cycles); Pass=1.
